ce_period_meter: RTL and testbench

CE_PERIOD_METER -- requirements
Module: ce_period_meter

---
 rtl/ce_period_meter.sv | 126 ++++++++++++
 tb/tb_ce_period_meter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ce_period_meter.sv
// ce_period_meter
//
// Measures the spacing of a clock-enable pulse stream. The reported divisor
// is the number of non-CE cycles between two consecutive i_ce pulses, so
// pulses D+1 cycles apart report D and back-to-back pulses report 0.
// The meter locks after LOCK_CNT consecutive equal measurements.
//
// Ports:
//   i_clk      single clock, all state changes on the rising edge
//   i_arstn    synchronous active-low reset (highest priority)
//   i_ce       pulse stream under measurement, synchronous to i_clk
//   i_clr      synchronous clear of measurement state and sticky timeout
//   o_div      last measured divisor (WIDTH bits, retained across clear/timeout)
//   o_valid    one-cycle pulse, o_div updated this cycle
//   o_lock     LOCK_CNT consecutive equal measurements seen
//   o_timeout  sticky: period counter saturated without a pulse
//
// Parameters:
//   WIDTH      width of the period counter and the divisor
//   LOCK_CNT   equal measurements needed for lock, 2..15

module ce_period_meter #(
    parameter int WIDTH    = 32,
    parameter int LOCK_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_ce,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_div,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_timeout
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [3:0]       LOCK_MATCH = 4'(LOCK_CNT);
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [3:0]       match_r;
    logic [3:0]       match_next_s;

    // Next match count for a measurement taken this cycle. match_r is zero
    // only before the first measurement after reset/clear/timeout, so a zero
    // value marks the first measurement and starts the run at one.
    always_comb begin
        match_next_s = 4'd1;
        if (match_r == 4'd0) begin
            match_next_s = 4'd1;
        end else if (cnt_r != o_div) begin
            match_next_s = 4'd1;
        end else if (match_r >= LOCK_MATCH) begin
            match_next_s = LOCK_MATCH;
        end else begin
            match_next_s = match_r + 4'd1;
        end
    end

    // Measurement FSM with all outputs registered; reset beats clear beats CE.
    always_ff @(posedge i_clk) begin
        if (!i_arstn) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            match_r   <= 4'd0;
            o_div     <= '0;
            o_valid   <= 1'b0;
            o_lock    <= 1'b0;
            o_timeout <= 1'b0;
        end else if (i_clr) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            match_r   <= 4'd0;
            o_valid   <= 1'b0;
            o_lock    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    // First pulse only opens the measurement window.
                    cnt_r <= '0;
                    if (i_ce) begin
                        state_r <= MEASURE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEASURE: begin
                    if (i_ce) begin
                        // A pulse on the saturated count is still a valid
                        // measurement, it is not a timeout.
                        o_div   <= cnt_r;
                        o_valid <= 1'b1;
                        cnt_r   <= '0;
                        match_r <= match_next_s;
                        o_lock  <= (match_next_s == LOCK_MATCH);
                    end else if (cnt_r == CNT_MAX) begin
                        // Counter would wrap: give up and wait for a new
                        // first pulse. o_div keeps the last good value.
                        o_timeout <= 1'b1;
                        state_r   <= IDLE;
                        match_r   <= 4'd0;
                        o_lock    <= 1'b0;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    match_r <= 4'd0;
                    o_lock  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ce_period_meter.sv
// Directed bench for ce_period_meter with WIDTH=4 (so the counter can
// saturate quickly) and LOCK_CNT=4. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns after the following rising edge.

module tb_ce_period_meter;

    logic       clk;
    logic       arstn;
    logic       ce;
    logic       clr;
    logic [3:0] div;
    logic       valid;
    logic       lock;
    logic       timeout;

    int tests;
    int fails;

    ce_period_meter #(
        .WIDTH    (4),
        .LOCK_CNT (4)
    ) u_dut (
        .i_clk     (clk),
        .i_arstn   (arstn),
        .i_ce      (ce),
        .i_clr     (clr),
        .o_div     (div),
        .o_valid   (valid),
        .o_lock    (lock),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 ns after the edge.
    task automatic cyc(input logic c, input logic cl, input logic rn);
        ce    = c;
        clr   = cl;
        arstn = rn;
        @(posedge clk);
        #1;
        ce    = 1'b0;
        clr   = 1'b0;
        arstn = 1'b1;
    endtask

    // n cycles without a pulse; o_valid must stay low throughout.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (i == 0) chk({tag, "_novalid"}, valid, 0);
        end
    endtask

    // One pulse cycle followed by checks on the registered result.
    task automatic pulse(input string tag, input logic ev, input int ed, input logic el);
        cyc(1'b1, 1'b0, 1'b1);
        chk({tag, "_valid"}, valid, ev);
        if (ev) chk({tag, "_div"}, div, ed);
        chk({tag, "_lock"}, lock, el);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_div"}, div, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ce    = 1'b0;
        clr   = 1'b0;
        arstn = 1'b0;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        all_zero("reset");

        // D=5 stream: first pulse silent, lock on the 4th measurement
        pulse("d5_first", 1'b0, 0, 1'b0);
        idle(5, "d5_gap1"); pulse("d5_m1", 1'b1, 5, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("valid_one_cycle", valid, 0);
        idle(4, "d5_gap2"); pulse("d5_m2", 1'b1, 5, 1'b0);
        idle(5, "d5_gap3"); pulse("d5_m3", 1'b1, 5, 1'b0);
        idle(5, "d5_gap4"); pulse("d5_m4", 1'b1, 5, 1'b1);
        idle(5, "d5_gap5"); pulse("d5_m5", 1'b1, 5, 1'b1);

        // Early pulse drops lock; relock after four more D=5 periods
        idle(2, "early_gap"); pulse("early", 1'b1, 2, 1'b0);
        idle(5, "re_gap1"); pulse("re_m1", 1'b1, 5, 1'b0);
        idle(5, "re_gap2"); pulse("re_m2", 1'b1, 5, 1'b0);
        idle(5, "re_gap3"); pulse("re_m3", 1'b1, 5, 1'b0);
        idle(5, "re_gap4"); pulse("re_m4", 1'b1, 5, 1'b1);

        // Clear together with CE while locked: CE ignored, div retained
        idle(5, "clr_gap");
        cyc(1'b1, 1'b1, 1'b1);
        chk("clrce_valid", valid, 0);
        chk("clrce_lock", lock, 0);
        chk("clrce_div", div, 5);
        idle(5, "clr_gap2"); pulse("clr_first", 1'b0, 0, 1'b0);
        idle(5, "clr_gap3"); pulse("clr_m1", 1'b1, 5, 1'b0);

        // Reset mid-period at D=7 discards the partial count
        idle(3, "rst_gap");
        cyc(1'b0, 1'b0, 1'b0);
        all_zero("midrst");
        idle(7, "rst_gap2"); pulse("rst_first", 1'b0, 0, 1'b0);
        idle(7, "rst_gap3"); pulse("rst_m1", 1'b1, 7, 1'b0);

        // CE held high: divisor 0 every cycle, lock after 4 measurements
        cyc(1'b0, 1'b1, 1'b1);
        chk("clr_div_kept", div, 7);
        pulse("b2b_first", 1'b0, 0, 1'b0);
        pulse("b2b_m1", 1'b1, 0, 1'b0);
        pulse("b2b_m2", 1'b1, 0, 1'b0);
        pulse("b2b_m3", 1'b1, 0, 1'b0);
        pulse("b2b_m4", 1'b1, 0, 1'b1);

        // Pulse on the saturated count is a measurement, not a timeout
        idle(15, "sat_gap"); pulse("sat", 1'b1, 15, 1'b0);
        chk("sat_timeout", timeout, 0);

        // Lock at D=1, then let the counter saturate
        idle(1, "d1_gap1"); pulse("d1_m1", 1'b1, 1, 1'b0);
        idle(1, "d1_gap2"); pulse("d1_m2", 1'b1, 1, 1'b0);
        idle(1, "d1_gap3"); pulse("d1_m3", 1'b1, 1, 1'b0);
        idle(1, "d1_gap4"); pulse("d1_m4", 1'b1, 1, 1'b1);
        idle(15, "to_gap");
        chk("to_not_yet", timeout, 0);
        chk("to_lock_held", lock, 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("to_flag", timeout, 1);
        chk("to_lock", lock, 0);
        chk("to_valid", valid, 0);
        chk("to_div_kept", div, 1);

        // Timeout is sticky across a restarted measurement
        pulse("to_first", 1'b0, 0, 1'b0);
        chk("to_sticky1", timeout, 1);
        idle(1, "to_gap2"); pulse("to_m1", 1'b1, 1, 1'b0);
        chk("to_sticky2", timeout, 1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("to_clr", timeout, 0);
        chk("to_clr_div", div, 1);

        // Reset wins over clear and CE
        cyc(1'b1, 1'b1, 1'b0);
        all_zero("rst_prio");
        pulse("prio_first", 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
